// File: rtl/fp_addsub_scheduler_pkg.sv
// Shared encodings and tracker entry layout for the FP add/sub scheduler.
// No logic; constants, one struct and a zero-extension helper.
// No handshake of its own.
package fp_addsub_scheduler_pkg;

    localparam logic MODE_SP = 1'b0;
    localparam logic MODE_DP = 1'b1;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    localparam int DATA_W    = 64;
    localparam int LANE0_LSB = 0;
    localparam int LANE0_MSB = 31;
    localparam int LANE1_LSB = 32;
    localparam int LANE1_MSB = 63;

    // Control part of one in-flight issue; tags travel in parallel arrays
    // because their width is a module parameter.
    typedef struct packed {
        logic vld;
        logic mode;
        logic l0_vld;
        logic l0_own;
        logic l1_vld;
    } trk_ctl_t;

    function automatic logic [DATA_W-1:0] sp_zext(input logic [31:0] v);
        return {32'b0, v};
    endfunction

endpackage

// File: rtl/fp_rsp_fifo.sv
// Per-requester response FIFO, DEPTH x {64b data, tag}, registered head.
// Push to visible head: 1 cycle. Head reads 0 while empty.
// No internal backpressure: push on full is only taken with a same-cycle pop; flush wins.
module fp_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents are don't-care while not counted, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; flush drops everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/fp_addsub_scheduler.sv
// Round-robin issue of two requesters onto a dual-SP/single-DP add/sub datapath, packing SP pairs.
// Issue is combinational in the handshake cycle; response visible LAT+1 cycles after acceptance.
// req_ready drops when a requester has no credit (response FIFO space incl. in-flight) or on flush.
module fp_addsub_scheduler
    import fp_addsub_scheduler_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_mode,
    input  logic [1:0]            req_op,
    input  logic [1:0][63:0]      req_a,
    input  logic [1:0][63:0]      req_b,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic                  dp_valid,
    output logic                  dp_mode,
    output logic [1:0]            dp_op,
    output logic [63:0]           dp_a,
    output logic [63:0]           dp_b,
    input  logic [63:0]           dp_res,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [1:0][63:0]      rsp_data,
    output logic [1:0][TAG_W-1:0] rsp_tag
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = DATA_W + TAG_W;

    logic [1:0]          elig, grant, pop, empty, full;
    logic                rr_q, rr_d, own;
    logic [1:0][CW-1:0]  credit_q, credit_d;
    trk_ctl_t            trk_in, trk_last;
    logic [TAG_W-1:0]    tag0_in, tag1_in;
    trk_ctl_t            ctl_q  [LAT];
    logic [TAG_W-1:0]    tag0_q [LAT];
    logic [TAG_W-1:0]    tag1_q [LAT];
    logic [1:0]          push_vld;
    logic [1:0][FW-1:0]  push_dat, head;

    // Arbiter: SP pair packs without moving the pointer, else round-robin single grant.
    // rst_n gating keeps the handshake quiet while reset is held.
    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_valid[i] & (credit_q[i] != '0) & ~i_flush & rst_n;
        end
        if ((&elig) && (req_mode == {MODE_SP, MODE_SP})) begin
            grant = 2'b11;
        end else if (elig[rr_q]) begin
            grant[rr_q] = 1'b1;
            rr_d        = ~rr_q;
        end else if (elig[~rr_q]) begin
            grant[~rr_q] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign own       = grant[1];

    // Datapath drive and tracker entry for this cycle's issue; all zero when idle.
    always_comb begin
        dp_valid = 1'b0;
        dp_mode  = MODE_SP;
        dp_op    = '0;
        dp_a     = '0;
        dp_b     = '0;
        trk_in   = '0;
        tag0_in  = '0;
        tag1_in  = '0;
        if (grant == 2'b11) begin
            dp_valid      = 1'b1;
            dp_op         = req_op;
            dp_a          = {req_a[1][LANE0_MSB:LANE0_LSB], req_a[0][LANE0_MSB:LANE0_LSB]};
            dp_b          = {req_b[1][LANE0_MSB:LANE0_LSB], req_b[0][LANE0_MSB:LANE0_LSB]};
            trk_in.l0_vld = 1'b1;
            trk_in.l1_vld = 1'b1;
            tag0_in       = req_tag[0];
            tag1_in       = req_tag[1];
        end else if (grant != 2'b00) begin
            dp_valid = 1'b1;
            dp_mode  = req_mode[own];
            if (req_mode[own] == MODE_DP) begin
                dp_op = {2{req_op[own]}};
                dp_a  = req_a[own];
                dp_b  = req_b[own];
            end else begin
                // Lone SP rides lane0; lane1 sees zeros and is never pushed.
                dp_op = {OP_ADD, req_op[own]};
                dp_a  = sp_zext(req_a[own][LANE0_MSB:LANE0_LSB]);
                dp_b  = sp_zext(req_b[own][LANE0_MSB:LANE0_LSB]);
            end
            trk_in.l0_vld = 1'b1;
            trk_in.l0_own = own;
            tag0_in       = req_tag[own];
        end
        trk_in.vld  = dp_valid;
        trk_in.mode = dp_mode;
    end

    // Tracker shift register; last stage lines up with dp_res. Flush kills all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                ctl_q[s]  <= '0;
                tag0_q[s] <= '0;
                tag1_q[s] <= '0;
            end
        end else if (i_flush) begin
            for (int s = 0; s < LAT; s++) ctl_q[s] <= '0;
        end else begin
            ctl_q[0]  <= trk_in;
            tag0_q[0] <= tag0_in;
            tag1_q[0] <= tag1_in;
            for (int s = 1; s < LAT; s++) begin
                ctl_q[s]  <= ctl_q[s-1];
                tag0_q[s] <= tag0_q[s-1];
                tag1_q[s] <= tag1_q[s-1];
            end
        end
    end

    assign trk_last = ctl_q[LAT-1];

    // Result steering: lane0 goes to its owner, lane1 only ever belongs to requester 1.
    always_comb begin
        push_vld[0] = trk_last.vld & trk_last.l0_vld & ~trk_last.l0_own;
        push_vld[1] = trk_last.vld & ((trk_last.l0_vld & trk_last.l0_own) | trk_last.l1_vld);
        push_dat[0] = {(trk_last.mode == MODE_DP) ? dp_res : sp_zext(dp_res[LANE0_MSB:LANE0_LSB]),
                       tag0_q[LAT-1]};
        if (trk_last.l1_vld) begin
            push_dat[1] = {sp_zext(dp_res[LANE1_MSB:LANE1_LSB]), tag1_q[LAT-1]};
        end else begin
            push_dat[1] = push_dat[0];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        fp_rsp_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (i_flush),
            .push_i     (push_vld[i]),
            .push_dat_i (push_dat[i]),
            .pop_i      (rsp_ready[i]),
            .head_o     (head[i]),
            .empty_o    (empty[i]),
            .full_o     (full[i])
        );
        assign rsp_valid[i] = ~empty[i];
        assign rsp_data[i]  = head[i][FW-1:TAG_W];
        assign rsp_tag[i]   = head[i][TAG_W-1:0];
        assign pop[i]       = rsp_valid[i] & rsp_ready[i];
    end

    // Credit next-state: grant spends one, pop returns one, both together cancel.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            credit_d[i] = credit_q[i];
            if (grant[i] && !pop[i])      credit_d[i] = credit_q[i] - CW'(1);
            else if (pop[i] && !grant[i]) credit_d[i] = credit_q[i] + CW'(1);
        end
    end

    // Credits and rr pointer; flush returns credits since it empties both FIFOs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= {2{CW'(DEPTH)}};
            rr_q     <= 1'b0;
        end else if (i_flush) begin
            credit_q <= {2{CW'(DEPTH)}};
        end else begin
            credit_q <= credit_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Directed bench for fp_addsub_scheduler with a behavioural LAT-cycle datapath.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
// The bench always pops or holds rsp_ready explicitly per step.
module tb_fp_addsub_scheduler;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_flush;
    logic [1:0]            req_valid, req_ready, req_mode, req_op;
    logic [1:0][63:0]      req_a, req_b;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  dp_valid, dp_mode;
    logic [1:0]            dp_op;
    logic [63:0]           dp_a, dp_b, dp_res;
    logic [1:0]            rsp_valid, rsp_ready;
    logic [1:0][63:0]      rsp_data;
    logic [1:0][TAG_W-1:0] rsp_tag;

    int n_tests = 0;
    int n_fail  = 0;
    int pops0   = 0;
    int pops1   = 0;

    always #5 clk = ~clk;

    fp_addsub_scheduler #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .dp_valid(dp_valid), .dp_mode(dp_mode), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
        .dp_res(dp_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
    );

    // Datapath model: known FP vectors from a table, integer add/sub otherwise.
    function automatic logic [31:0] sp_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000;
        return op ? a - b : a + b;
    endfunction

    function automatic logic [63:0] dp_fn(input logic m, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        if (m) begin
            if (!op[0] && a == 64'h3FF0000000000000 && b == 64'h3FF0000000000000)
                return 64'h4000000000000000;
            return op[0] ? a - b : a + b;
        end
        return {sp_fn(a[63:32], b[63:32], op[1]), sp_fn(a[31:0], b[31:0], op[0])};
    endfunction

    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= dp_valid ? dp_fn(dp_mode, dp_op, dp_a, dp_b) : 64'hBAD0BAD0BAD0BAD0;
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign dp_res = pipe[LAT-1];

    always @(posedge clk) begin
        if (rsp_valid[0] && rsp_ready[0]) pops0 <= pops0 + 1;
        if (rsp_valid[1] && rsp_ready[1]) pops1 <= pops1 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0, p1, acc;
        logic any_vld;
        logic [3:0] exp_tag [4];
        exp_tag[0] = 4'd1; exp_tag[1] = 4'd2; exp_tag[2] = 4'd3; exp_tag[3] = 4'd9;

        rst_n = 1'b0; i_flush = 1'b0; req_valid = '0; req_mode = '0; req_op = '0;
        req_a = '0; req_b = '0; req_tag = '0; rsp_ready = '0;
        wait_neg(2);
        chk("reset_ctl", 64'({req_ready, dp_valid, dp_mode, dp_op, rsp_valid}), 64'd0);
        chk("reset_data", rsp_data[0] | rsp_data[1] | 64'({rsp_tag[0], rsp_tag[1]}), 64'd0);
        rst_n = 1'b1;
        wait_neg(1);

        // 1: lone DP add 1.0 + 1.0
        req_valid = 2'b01; req_mode = 2'b01; req_op = 2'b00;
        req_a[0] = 64'h3FF0000000000000; req_b[0] = 64'h3FF0000000000000; req_tag[0] = 4'd3;
        #1;
        chk("t1_issue", 64'({req_ready, dp_valid, dp_mode, dp_op}), 64'b01_1_1_00);
        chk("t1_dp_a", dp_a, 64'h3FF0000000000000);
        wait_neg(1); req_valid = '0;
        wait_neg(3);
        chk("t1_not_early", 64'(rsp_valid), 64'd0);
        wait_neg(1);
        chk("t1_rsp_vld", 64'(rsp_valid), 64'b01);
        chk("t1_rsp_data", rsp_data[0], 64'h4000000000000000);
        chk("t1_rsp_tag", 64'(rsp_tag[0]), 64'd3);
        rsp_ready = 2'b01; wait_neg(1); rsp_ready = '0;
        chk("t1_popped", 64'(rsp_valid), 64'd0);

        // 2: SP pair packs into one issue
        req_valid = 2'b11; req_mode = 2'b00; req_op = 2'b10;
        req_a[0] = 64'h3F800000; req_b[0] = 64'h40000000; req_tag[0] = 4'd1;
        req_a[1] = 64'h40A00000; req_b[1] = 64'h3F800000; req_tag[1] = 4'd2;
        #1;
        chk("t2_issue", 64'({req_ready, dp_valid, dp_mode, dp_op}), 64'b11_1_0_10);
        chk("t2_dp_a", dp_a, 64'h40A000003F800000);
        chk("t2_dp_b", dp_b, 64'h3F80000040000000);
        wait_neg(1); req_valid = '0;
        wait_neg(4);
        chk("t2_rsp_vld", 64'(rsp_valid), 64'b11);
        chk("t2_rsp0", rsp_data[0], 64'h40400000);
        chk("t2_rsp1", rsp_data[1], 64'h40800000);
        chk("t2_tags", 64'({rsp_tag[1], rsp_tag[0]}), 64'h21);
        rsp_ready = 2'b11; wait_neg(1); rsp_ready = '0;

        // 2b: lone SP from requester 1, upper operand bits must not leak
        req_valid = 2'b10; req_op = 2'b10;
        req_a[1] = 64'hDEADBEEF00000005; req_b[1] = 64'hCAFEF00D00000002; req_tag[1] = 4'd5;
        #1;
        chk("t2b_issue", 64'({req_ready, dp_valid, dp_mode, dp_op}), 64'b10_1_0_01);
        chk("t2b_dp_a", dp_a, 64'h5);
        chk("t2b_dp_b", dp_b, 64'h2);
        wait_neg(1); req_valid = '0;
        wait_neg(4);
        chk("t2b_rsp", {rsp_data[1][59:0], rsp_tag[1]}, {60'h3, 4'd5});
        chk("t2b_vld", 64'(rsp_valid), 64'b10);
        rsp_ready = 2'b10; wait_neg(1); rsp_ready = '0;

        // 3: DP vs SP, no packing, strict alternation from requester 0
        p0 = pops0; p1 = pops1;
        req_valid = 2'b11; req_mode = 2'b01; req_op = 2'b00; rsp_ready = 2'b11;
        req_a[0] = 64'h3FF0000000000000; req_b[0] = 64'h3FF0000000000000; req_tag[0] = 4'd6;
        req_a[1] = 64'h1; req_b[1] = 64'h1; req_tag[1] = 4'd7;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_alt", 64'({req_ready, dp_mode}), (k % 2 == 0) ? 64'b01_1 : 64'b10_0);
            wait_neg(1);
        end
        req_valid = '0;
        wait_neg(LAT + 2);
        chk("t3_pops", 64'({16'(pops0 - p0), 16'(pops1 - p1)}), {32'd0, 16'd3, 16'd3});
        rsp_ready = '0;

        // 4: credit exhaustion and single-credit restore
        req_valid = 2'b01; req_mode = 2'b00; req_op = 2'b00; req_b[0] = 64'h1;
        for (int k = 0; k < 6; k++) begin
            req_a[0] = 64'(k); req_tag[0] = 4'(k);
            #1;
            chk("t4_credit", 64'(req_ready), (k < DEPTH) ? 64'b01 : 64'b00);
            wait_neg(1);
        end
        req_a[0] = 64'd9; req_tag[0] = 4'd9;
        wait_neg(LAT);
        chk("t4_full", 64'({req_ready, rsp_valid}), 64'b00_01);
        chk("t4_head", {rsp_data[0][59:0], rsp_tag[0]}, {60'h1, 4'd0});
        rsp_ready = 2'b01; #1;
        chk("t4_pop_cycle", 64'(req_ready), 64'b00);
        wait_neg(1); rsp_ready = '0; #1;
        chk("t4_restore", 64'(req_ready), 64'b01);
        wait_neg(1); #1;
        chk("t4_one_only", 64'(req_ready), 64'b00);
        req_valid = '0;
        wait_neg(LAT + 1);
        rsp_ready = 2'b01;
        for (int j = 0; j < 4; j++) begin
            chk("t4_order", {rsp_data[0][58:0], rsp_valid[0], rsp_tag[0]},
                {59'(exp_tag[j]) + 59'd1, 1'b1, exp_tag[j]});
            wait_neg(1);
        end
        rsp_ready = '0;
        chk("t4_drained", 64'(rsp_valid), 64'd0);

        // 5: flush two cycles after three issues
        p0 = pops0;
        rsp_ready = 2'b11; req_valid = 2'b01; req_a[0] = 64'd7; req_b[0] = 64'd1; req_tag[0] = 4'hA;
        wait_neg(3);
        req_valid = '0;
        wait_neg(1);
        i_flush = 1'b1; req_valid = 2'b01; #1;
        chk("t5_flush_block", 64'({req_ready, dp_valid}), 64'd0);
        wait_neg(1);
        i_flush = 1'b0; req_valid = '0;
        any_vld = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            any_vld = any_vld | (|rsp_valid);
            wait_neg(1);
        end
        chk("t5_no_stale", 64'({any_vld, 16'(pops0 - p0)}), 64'd0);
        rsp_ready = '0; acc = 0;
        req_valid = 2'b01; req_a[0] = 64'd100; req_b[0] = 64'd23; req_tag[0] = 4'd7;
        for (int k = 0; k < 6; k++) begin
            #1; acc += int'(req_ready[0]);
            wait_neg(1);
        end
        req_valid = '0;
        chk("t5_credits", 64'(acc), 64'd4);
        wait_neg(LAT);
        chk("t5_after", {rsp_data[0][58:0], rsp_valid, rsp_tag[0]}, {59'h7B, 2'b01, 4'd7});

        // 6: asynchronous reset with a full FIFO and an op in flight
        req_valid = 2'b10; req_a[1] = 64'd1; req_b[1] = 64'd1; req_tag[1] = 4'd2;
        wait_neg(1);
        req_valid = 2'b11;
        #2; rst_n = 1'b0; #1;
        chk("t6_async_ctl", 64'({req_ready, dp_valid, dp_mode, dp_op, rsp_valid}), 64'd0);
        chk("t6_async_data", dp_a | rsp_data[0] | rsp_data[1] | 64'({rsp_tag[0], rsp_tag[1]}), 64'd0);
        wait_neg(1);
        req_valid = '0; rst_n = 1'b1;
        any_vld = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            any_vld = any_vld | (|rsp_valid);
            wait_neg(1);
        end
        chk("t6_quiet", 64'(any_vld), 64'd0);
        req_valid = 2'b10; req_a[1] = 64'd1; req_b[1] = 64'd2; req_op = 2'b00; req_tag[1] = 4'd4;
        #1;
        chk("t6_new_issue", 64'(req_ready), 64'b10);
        wait_neg(1); req_valid = '0;
        wait_neg(4);
        chk("t6_new_rsp", {rsp_data[1][57:0], rsp_valid, rsp_tag[1]}, {58'd3, 2'b10, 4'd4});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
